// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the register-block response path.
//   - Response status encodings ({exokay, slave_error}).
//   - Response FSM state type.
//   - Helper to size the wait-state timeout counter.
package rggen_rtl_pkg;

    localparam logic [1:0] RGGEN_OKAY        = 2'b00;
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b01;
    localparam logic [1:0] RGGEN_EXOKAY      = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RESPOND = 2'b10
    } rggen_response_state_e;

    // Width needed to hold 0..timeout_cycles, never narrower than one bit
    // so a disabled timeout still yields a legal vector.
    function automatic int rggen_counter_width(input int timeout_cycles);
        int width;
        if (timeout_cycles > 0) begin
            width = $clog2(timeout_cycles + 1);
        end else begin
            width = 1;
        end
        if (width < 1) begin
            width = 1;
        end else begin
            width = width;
        end
        return width;
    endfunction

endpackage

// File: rtl/rggen_onehot_mux.sv
// Mask-and-OR selector: ORs together every entry whose select bit is set.
// With a one-hot select this is a plain multiplexer; with several bits set
// it yields the bitwise OR of the selected entries.
//   i_select : ENTRIES-bit select vector
//   i_data   : ENTRIES entries of WIDTH bits
//   o_data   : OR of the selected entries (0 when nothing is selected)
module rggen_onehot_mux #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 1
) (
    input  logic [ENTRIES-1:0] i_select,
    input  logic [WIDTH-1:0]   i_data [ENTRIES],
    output logic [WIDTH-1:0]   o_data
);

    logic [WIDTH-1:0] result_s;

    // Accumulate the OR of all selected entries.
    always_comb begin
        result_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (i_select[i]) begin
                result_s = result_s | i_data[i];
            end else begin
                result_s = result_s;
            end
        end
    end

    assign o_data = result_s;

endmodule

// File: rtl/rggen_wait_response_mux.sv
// Response multiplexer with wait-state support for the register block.
// Picks the read data of the addressed register, waits for that register's
// ready flag, closes stalled accesses with a slave error after
// TIMEOUT_CYCLES, and flags empty / multiple selects as decode errors.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_command_valid       : command pending, held stable until the response
//   i_read                : 1 = read, 0 = write
//   o_response_ready      : one-cycle response strobe
//   o_read_data           : read data, non-zero only with o_response_ready
//   o_status              : {exokay, slave_error}, valid with o_response_ready
//   i_register_select     : decoded register select
//   i_register_ready      : per-register access-complete flag
//   i_register_read_data  : per-register read values
module rggen_wait_response_mux
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int TOTAL_REGISTERS       = 1,
    parameter int TIMEOUT_CYCLES        = 0,
    parameter bit ERROR_ON_MULTI_SELECT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_command_valid,
    input  logic                       i_read,
    output logic                       o_response_ready,
    output logic [DATA_WIDTH-1:0]      o_read_data,
    output logic [1:0]                 o_status,
    input  logic [TOTAL_REGISTERS-1:0] i_register_select,
    input  logic [TOTAL_REGISTERS-1:0] i_register_ready,
    input  logic [DATA_WIDTH-1:0]      i_register_read_data [TOTAL_REGISTERS]
);

    localparam int COUNTER_WIDTH = rggen_counter_width(TIMEOUT_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? COUNTER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    rggen_response_state_e     state_r;
    rggen_response_state_e     state_next_s;
    logic [COUNTER_WIDTH-1:0]  counter_r;
    logic [COUNTER_WIDTH-1:0]  counter_next_s;
    logic                      response_ready_r;
    logic                      response_ready_next_s;
    logic [DATA_WIDTH-1:0]     read_data_r;
    logic [DATA_WIDTH-1:0]     read_data_next_s;
    logic [1:0]                status_r;
    logic [1:0]                status_next_s;

    logic [DATA_WIDTH-1:0]     selected_data_s;
    logic [0:0]                ready_array_s [TOTAL_REGISTERS];
    logic [0:0]                selected_ready_s;
    logic                      multi_select_s;
    logic                      decode_error_s;
    logic [DATA_WIDTH-1:0]     ok_data_s;

    rggen_onehot_mux #(
        .WIDTH   (DATA_WIDTH),
        .ENTRIES (TOTAL_REGISTERS)
    ) u_data_mux (
        .i_select (i_register_select),
        .i_data   (i_register_read_data),
        .o_data   (selected_data_s)
    );

    // Repack the ready vector so the same selector can reduce it.
    always_comb begin
        for (int i = 0; i < TOTAL_REGISTERS; i++) begin
            ready_array_s[i] = i_register_ready[i];
        end
    end

    rggen_onehot_mux #(
        .WIDTH   (1),
        .ENTRIES (TOTAL_REGISTERS)
    ) u_ready_mux (
        .i_select (i_register_select),
        .i_data   (ready_array_s),
        .o_data   (selected_ready_s)
    );

    // x & (x - 1) clears the lowest set bit; anything left means 2+ bits set.
    assign multi_select_s = |(i_register_select &
                              (i_register_select - TOTAL_REGISTERS'(1)));
    assign decode_error_s = (i_register_select == '0) ||
                            (ERROR_ON_MULTI_SELECT && multi_select_s);
    // Only an OK read returns data; writes complete with zero.
    assign ok_data_s      = i_read ? selected_data_s : '0;

    // Next-state, counter and next-response decision.
    always_comb begin
        state_next_s          = state_r;
        counter_next_s        = counter_r;
        response_ready_next_s = 1'b0;
        read_data_next_s      = '0;
        status_next_s         = RGGEN_OKAY;
        case (state_r)
            IDLE: begin
                counter_next_s = '0;
                if (i_command_valid) begin
                    if (decode_error_s) begin
                        state_next_s          = RESPOND;
                        response_ready_next_s = 1'b1;
                        status_next_s         = RGGEN_SLAVE_ERROR;
                    end else if (selected_ready_s[0]) begin
                        state_next_s          = RESPOND;
                        response_ready_next_s = 1'b1;
                        read_data_next_s      = ok_data_s;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (!i_command_valid) begin
                    // Bus withdrew the command: abandon silently.
                    state_next_s   = IDLE;
                    counter_next_s = '0;
                end else if (selected_ready_s[0]) begin
                    // Ready wins over a timeout landing in the same cycle.
                    state_next_s          = RESPOND;
                    response_ready_next_s = 1'b1;
                    read_data_next_s      = ok_data_s;
                    counter_next_s        = '0;
                end else if ((TIMEOUT_CYCLES > 0) && (counter_r == TIMEOUT_LAST)) begin
                    state_next_s          = RESPOND;
                    response_ready_next_s = 1'b1;
                    status_next_s         = RGGEN_SLAVE_ERROR;
                    counter_next_s        = '0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    counter_next_s = counter_r + COUNTER_WIDTH'(1);
                end else begin
                    // Timeout disabled: counter is irrelevant, hold it.
                    counter_next_s = counter_r;
                end
            end
            RESPOND: begin
                // Command still high here belongs to the finished access.
                state_next_s   = IDLE;
                counter_next_s = '0;
            end
            default: begin
                state_next_s   = IDLE;
                counter_next_s = '0;
            end
        endcase
    end

    // State, counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            counter_r        <= '0;
            response_ready_r <= 1'b0;
            read_data_r      <= '0;
            status_r         <= RGGEN_OKAY;
        end else begin
            state_r          <= state_next_s;
            counter_r        <= counter_next_s;
            response_ready_r <= response_ready_next_s;
            read_data_r      <= read_data_next_s;
            status_r         <= status_next_s;
        end
    end

    assign o_response_ready = response_ready_r;
    assign o_read_data      = read_data_r;
    assign o_status         = status_r;

endmodule

// File: tb/tb_rggen_wait_response_mux.sv
// Scoreboard bench for rggen_wait_response_mux. Two instances share the
// register-side stimulus: dut_a (TIMEOUT_CYCLES=8, multi-select error on)
// and dut_b (TIMEOUT_CYCLES=4, multi-select error off). Each has its own
// command_valid, dropped once that instance responds, like a real bus.
module tb_rggen_wait_response_mux;

    localparam int N = 4;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [1:0]  status;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_a;
    logic        cmd_b;
    logic        rd;
    logic [N-1:0] sel;
    logic [N-1:0] rdy;
    logic [31:0] rdata [N];
    logic        resp_a;
    logic        resp_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [1:0]  st_a;
    logic [1:0]  st_b;

    int   edge_cnt;
    int   checks;
    int   failures;
    exp_t q_a[$];
    exp_t q_b[$];

    rggen_wait_response_mux #(
        .DATA_WIDTH(32), .TOTAL_REGISTERS(N), .TIMEOUT_CYCLES(8), .ERROR_ON_MULTI_SELECT(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cmd_a), .i_read(rd),
        .o_response_ready(resp_a), .o_read_data(data_a), .o_status(st_a),
        .i_register_select(sel), .i_register_ready(rdy), .i_register_read_data(rdata)
    );

    rggen_wait_response_mux #(
        .DATA_WIDTH(32), .TOTAL_REGISTERS(N), .TIMEOUT_CYCLES(4), .ERROR_ON_MULTI_SELECT(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cmd_b), .i_read(rd),
        .o_response_ready(resp_b), .o_read_data(data_b), .o_status(st_b),
        .i_register_select(sel), .i_register_ready(rdy), .i_register_read_data(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    // Monitor: pop and compare on every response; outputs must be zero otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (resp_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_response", 64'd1, 64'd0);
            end else begin
                e = q_a.pop_front();
                check("a_latency", 64'(edge_cnt), 64'(e.cyc));
                check("a_response", {30'd0, st_a, data_a}, {30'd0, e.status, e.data});
            end
        end else begin
            check("a_idle_zero", {30'd0, st_a, data_a}, 64'd0);
        end
        if (resp_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_response", 64'd1, 64'd0);
            end else begin
                e = q_b.pop_front();
                check("b_latency", 64'(edge_cnt), 64'(e.cyc));
                check("b_response", {30'd0, st_b, data_b}, {30'd0, e.status, e.data});
            end
        end else begin
            check("b_idle_zero", {30'd0, st_b, data_b}, 64'd0);
        end
    end

    // Issue one command. lat_x < 0 means no response expected from that DUT.
    // Ready mask is rbase before cycle rfrom and all-ones from it on.
    task automatic drive(input logic [N-1:0] s, input logic r, input logic [N-1:0] rbase,
                         input int rfrom, input int drop_at, input int budget,
                         input int lat_a, input logic [31:0] d_a, input logic [1:0] s_a,
                         input int lat_b, input logic [31:0] d_b, input logic [1:0] s_b);
        int   start;
        logic done_a;
        logic done_b;
        exp_t e;
        @(negedge clk);
        start  = edge_cnt;
        done_a = 1'b0;
        done_b = 1'b0;
        if (lat_a >= 0) begin
            e.cyc = start + lat_a; e.data = d_a; e.status = s_a; q_a.push_back(e);
        end
        if (lat_b >= 0) begin
            e.cyc = start + lat_b; e.data = d_b; e.status = s_b; q_b.push_back(e);
        end
        sel = s;
        rd  = r;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (resp_a === 1'b1) done_a = 1'b1;
                if (resp_b === 1'b1) done_b = 1'b1;
            end
            rdy   = (c >= rfrom) ? 4'b1111 : rbase;
            cmd_a = (c < drop_at) && !done_a;
            cmd_b = (c < drop_at) && !done_b;
            if (done_a && done_b) break;
        end
        cmd_a = 1'b0;
        cmd_b = 1'b0;
        rdy   = 4'b0000;
        sel   = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_a"}, {31'd0, resp_a, st_a, data_a}, 64'd0);
        check({name, "_b"}, {31'd0, resp_b, st_b, data_b}, 64'd0);
    endtask

    initial begin
        edge_cnt = 0;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        cmd_a    = 1'b0;
        cmd_b    = 1'b0;
        rd       = 1'b0;
        sel      = 4'b0000;
        rdy      = 4'b0000;
        rdata[0] = 32'h0000_00F0;
        rdata[1] = 32'h1234_5600;
        rdata[2] = 32'hA5A5_0001;
        rdata[3] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait read: latency 1.
        drive(4'b0100, 1'b1, 4'b1111, 0, 99, 6, 1, 32'hA5A5_0001, 2'b00, 1, 32'hA5A5_0001, 2'b00);
        // Ready on slot 1 rises at cycle 3: response at cycle 4.
        drive(4'b0010, 1'b1, 4'b1101, 3, 99, 10, 4, 32'h1234_5600, 2'b00, 4, 32'h1234_5600, 2'b00);
        // Same as a write: data 0.
        drive(4'b0010, 1'b0, 4'b1101, 3, 99, 10, 4, 32'h0, 2'b00, 4, 32'h0, 2'b00);
        // Never ready: timeout at TIMEOUT+1 (9 for a, 5 for b).
        drive(4'b0010, 1'b1, 4'b1101, 999, 99, 14, 9, 32'h0, 2'b01, 5, 32'h0, 2'b01);
        // Ready rising exactly on the timeout cycle of b: ready wins.
        drive(4'b0010, 1'b1, 4'b1101, 4, 99, 10, 5, 32'h1234_5600, 2'b00, 5, 32'h1234_5600, 2'b00);
        // Empty select: decode error at cycle 1.
        drive(4'b0000, 1'b1, 4'b1111, 0, 99, 6, 1, 32'h0, 2'b01, 1, 32'h0, 2'b01);
        // Multi-select: error on a, OR of slots 0 and 1 on b.
        drive(4'b0011, 1'b1, 4'b1111, 0, 99, 6, 1, 32'h0, 2'b01, 1, 32'h1234_56F0, 2'b00);
        // Command withdrawn at cycle 2 of a wait: no response.
        drive(4'b0010, 1'b1, 4'b1101, 999, 2, 4, -1, 32'h0, 2'b00, -1, 32'h0, 2'b00);
        // Follow-up command after abort is accepted immediately.
        drive(4'b1000, 1'b1, 4'b1111, 0, 99, 6, 1, 32'hDEAD_BEEF, 2'b00, 1, 32'hDEAD_BEEF, 2'b00);
        // Zero-wait write.
        drive(4'b0100, 1'b0, 4'b1111, 0, 99, 6, 1, 32'h0, 2'b00, 1, 32'h0, 2'b00);

        // Reset while the response is on the outputs clears them at once.
        @(negedge clk);
        sel = 4'b0100; rd = 1'b1; rdy = 4'b1111; cmd_a = 1'b1; cmd_b = 1'b1;
        @(posedge clk);
        #1;
        check("respond_before_reset", {31'd0, resp_a, st_a, data_a}, {31'd0, 1'b1, 2'b00, 32'hA5A5_0001});
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset_respond");
        cmd_a = 1'b0; cmd_b = 1'b0; sel = 4'b0000; rdy = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during a wait: no response for the interrupted command.
        sel = 4'b0010; rd = 1'b1; rdy = 4'b1101; cmd_a = 1'b1; cmd_b = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset_wait");
        cmd_a = 1'b0; cmd_b = 1'b0; sel = 4'b0000; rdy = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive(4'b0100, 1'b1, 4'b1111, 0, 99, 6, 1, 32'hA5A5_0001, 2'b00, 1, 32'hA5A5_0001, 2'b00);

        repeat (3) @(negedge clk);
        check("a_missing_responses", 64'(q_a.size()), 64'd0);
        check("b_missing_responses", 64'(q_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rggen_wait_response_mux.md
# rggen_wait_response_mux

Parametrised successor to the single-cycle response multiplexer in the register block. It selects the read data and status of the addressed register, but also supports registers that need wait states through a per-register ready input. It adds a timeout counter that closes a stalled access with a slave error, and flags multiple-select decode faults. It sits between the register-block bus front end (command/response pulse protocol) and the register array.

## Interface
- DATA_WIDTH, 32, read data width.
- TOTAL_REGISTERS, 1, number of register slots (≥1).
- TIMEOUT_CYCLES, 0, wait-state limit in cycles; 0 disables the timeout (waits forever).
- ERROR_ON_MULTI_SELECT, 1, when 1 a command with more than one select bit set responds with slave error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_command_valid  input  1  command pending; bus holds it and all command inputs stable until o_response_ready.
- i_read  input  1  1 = read, 0 = write.
- o_response_ready  output  1  one-cycle response strobe.
- o_read_data  output  DATA_WIDTH  read data, valid with o_response_ready.
- o_status  output  2  {exokay, slave_error}, valid with o_response_ready.
- i_register_select  input  TOTAL_REGISTERS  decoded one-hot select.
- i_register_ready  input  TOTAL_REGISTERS  per-register access-complete flag; a register with no wait states ties its bit to 1.
- i_register_read_data  input  DATA_WIDTH × TOTAL_REGISTERS  unpacked array of register read values.

## Operation
- The FSM has three states: IDLE, WAIT and RESPOND. Reset puts it in IDLE.
- IDLE with i_command_valid:
  - Decode error (no select bit set, or a multi-select with ERROR_ON_MULTI_SELECT=1) → RESPOND with status 2'b01 and data 0.
  - Selected ready (OR of select & ready) = 1 → RESPOND with status 2'b00, capturing data.
  - Otherwise → WAIT, with the timeout counter cleared to 0.
- WAIT:
  - Selected ready → RESPOND with OK status, capturing data.
  - Counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES>0 → RESPOND with status 2'b01 and data 0.
  - Otherwise the counter increments by 1.
  - Ready has priority over timeout in the same cycle.
- RESPOND: o_response_ready=1 for exactly one cycle, then → IDLE unconditionally. i_command_valid still high in this cycle is ignored (no double response).
- i_command_valid dropping while in WAIT aborts the access → IDLE with no response and the counter cleared.
- Read data:
  - The OR of (select[i] ? data[i] : 0) over all slots, captured only for an OK read.
  - Writes and errors give 0.
  - o_read_data is 0 whenever o_response_ready=0.
- o_status is 2'b00 whenever o_response_ready=0. exokay is always 0 in this generation.
- Select, ready and data are sampled every cycle during WAIT; the bus guarantees select stability.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1. It never wraps, because it saturates the timeout decision.

## Timing
- Reset values: o_response_ready=0, o_read_data=0, o_status=2'b00, state IDLE, counter 0.
- Cycle 0 is the first cycle i_command_valid=1 in IDLE.
- Ready at cycle k (k ≥ 0) → o_response_ready at cycle k+1. A zero-wait register therefore gives latency 1, identical to the previous generation.
- Decode error → response at cycle 1.
- No ready in cycles 0..TIMEOUT_CYCLES → error response at cycle TIMEOUT_CYCLES+1.
- Minimum spacing between responses is 2 cycles (RESPOND → IDLE → accept).
- All outputs are registered; there is no combinational path from any input to any output.
- rst_n asserted mid-access forces all outputs to their reset values immediately. No response is issued for the interrupted command.

## Structure
- Shared package rggen_rtl_pkg holds:
  - Status constants RGGEN_OKAY=2'b00, RGGEN_SLAVE_ERROR=2'b01, RGGEN_EXOKAY=2'b10.
  - The state enum typedef rggen_response_state_e {IDLE, WAIT, RESPOND}.
- One sub-module: rggen_onehot_mux (parameters WIDTH and ENTRIES). It is combinational mask-and-OR selection and is reused for both the data path and the ready reduction (WIDTH=1).
- The FSM, counter and output registers stay in the top module.

## Test plan
- TOTAL_REGISTERS=4, select=4'b0100, ready=4'b1111, data[2]=32'hA5A5_0001, read at cycle 0 → response_ready at cycle 1, read_data=32'hA5A5_0001, status=2'b00; at cycle 2 response_ready=0 and read_data=0.
- Select=4'b0010, ready[1] low until cycle 3, TIMEOUT_CYCLES=8 → response at cycle 4, status 00, data from slot 1; write of the same → data 0.
- TIMEOUT_CYCLES=4, ready never → response at cycle 5 with status 2'b01 and data 0. Ready rising at exactly cycle 4 → OK response at cycle 5.
- Select=0 → response at cycle 1, status 01. Select=4'b0011 with ERROR_ON_MULTI_SELECT=1 → status 01. The same with 0 → OK and data = data[0]|data[1].
- Command dropped at cycle 2 of a wait → no response, FSM back in IDLE. A new command at cycle 4 with ready → response at cycle 5.
- rst_n pulsed low during WAIT → outputs 0 asynchronously. After release, a fresh command completes normally with a latency-1 response.
